// File: rtl/edge_pkg.sv
// Shared sizing and state encoding for the edge-map pipeline (buffer stage and OR-packer).
package edge_pkg;
    localparam int NUM_PIXELS = 22500;
    localparam int IDX_W      = 15;
    localparam int NUM_PASSES = 4;
    localparam int NUM_BYTES  = (NUM_PIXELS + 7) / 8;

    typedef enum logic [2:0] {IDLE, ACCUM, PACK, OUT, DONE} state_t;
endpackage

// File: rtl/edge_or_packer_if.sv
// Edge-bit input stream, packed-byte output stream and status for edge_or_packer.
// edge_count exists only when PIXEL_COUNT_EN is defined.
interface edge_or_packer_if #(parameter int IDX_W = edge_pkg::IDX_W);
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       busy;
    logic       done;
`ifdef PIXEL_COUNT_EN
    logic [IDX_W-1:0] edge_count;

    modport master (output start, bit_in, bit_valid, byte_ready,
                    input  byte_out, byte_valid, busy, done, edge_count);
    modport slave  (input  start, bit_in, bit_valid, byte_ready,
                    output byte_out, byte_valid, busy, done, edge_count);
`else
    // keeps the width parameter referenced when the count is compiled out
    localparam int unused_idx_w = IDX_W;

    modport master (output start, bit_in, bit_valid, byte_ready,
                    input  byte_out, byte_valid, busy, done);
    modport slave  (input  start, bit_in, bit_valid, byte_ready,
                    output byte_out, byte_valid, busy, done);
`endif
endinterface

// File: rtl/edge_bit_ram.sv
// 1-bit map storage: combinational read, write on posedge; read-modify-write uses one address.
// Latency: read 0 cycles, write visible next cycle. No backpressure.
module edge_bit_ram #(
    parameter int DEPTH  = 22500,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_dat,
    output logic              rd_dat
);
    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wr_dat;
    end

    assign rd_dat = mem[addr];
endmodule

// File: rtl/edge_or_packer.sv
// ORs NUM_PASSES serial edge-map passes, then packs the map LSB-first into bytes (optional PIXEL_COUNT_EN).
// Latency: first byte_valid 9 edges after the final pixel bit; each further byte 8 pack + 1 load cycle.
// Backpressure: byte held on byte_out/byte_valid until byte_ready; input side has none (bit_valid gaps ok).
module edge_or_packer
    import edge_pkg::*;
#(
    parameter int NUM_PIXELS = edge_pkg::NUM_PIXELS,
    parameter int IDX_W      = edge_pkg::IDX_W,
    parameter int NUM_PASSES = edge_pkg::NUM_PASSES
) (
    input  logic            clk,
    input  logic            reset,
    edge_or_packer_if.slave io
);
    localparam int PASS_W = $clog2(NUM_PASSES + 1);
    localparam int BYTE_W = IDX_W - 2;
    localparam int NBYTES = (NUM_PIXELS + 7) / 8;
    localparam logic [IDX_W-1:0]  LAST_PIX  = IDX_W'(NUM_PIXELS - 1);
    localparam logic [IDX_W:0]    PIX_LIMIT = (IDX_W + 1)'(NUM_PIXELS);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          byte_out_q, byte_out_d;
    logic                byte_valid_q, byte_valid_d;
    logic                ram_we, ram_wr_dat, ram_rd_dat, rd_bit;
`ifdef PIXEL_COUNT_EN
    logic [IDX_W-1:0]    edge_cnt_q, edge_cnt_d;
`endif

    edge_bit_ram #(.DEPTH(NUM_PIXELS), .ADDR_W(IDX_W)) u_map (
        .clk    (clk),
        .wr_en  (ram_we),
        .addr   (idx_q),
        .wr_dat (ram_wr_dat),
        .rd_dat (ram_rd_dat)
    );

    // Pass 0 ignores stale RAM contents; positions past the last pixel pack as zero padding.
    assign ram_wr_dat = ((pass_q == '0) ? 1'b0 : ram_rd_dat) | io.bit_in;
    assign rd_bit     = ram_rd_dat & ({1'b0, idx_q} < PIX_LIMIT);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pass_d       = pass_q;
        byte_cnt_d   = byte_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        ram_we       = 1'b0;
`ifdef PIXEL_COUNT_EN
        edge_cnt_d   = edge_cnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (io.start) begin
                    state_d    = ACCUM;
                    idx_d      = '0;
                    pass_d     = '0;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
`ifdef PIXEL_COUNT_EN
                    edge_cnt_d = '0;
`endif
                end
            end
            ACCUM: begin
                if (io.bit_valid) begin
                    ram_we = 1'b1;
                    if (idx_q == LAST_PIX) begin
                        idx_d  = '0;
                        pass_d = pass_q + 1'b1;
                        if (pass_q == LAST_PASS) state_d = PACK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PACK: begin
                shift_d   = {rd_bit, shift_q[7:1]};
                idx_d     = idx_q + 1'b1;
                bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef PIXEL_COUNT_EN
                if (rd_bit) edge_cnt_d = edge_cnt_q + 1'b1;
`endif
                if (bit_cnt_q == 3'd7) state_d = OUT;
            end
            OUT: begin
                if (!byte_valid_q) begin
                    byte_out_d   = shift_q;
                    byte_valid_d = 1'b1;
                end else if (io.byte_ready) begin
                    byte_valid_d = 1'b0;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = PACK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pass_q       <= '0;
            byte_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
`ifdef PIXEL_COUNT_EN
            edge_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pass_q       <= pass_d;
            byte_cnt_q   <= byte_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
`ifdef PIXEL_COUNT_EN
            edge_cnt_q   <= edge_cnt_d;
`endif
        end
    end

    assign io.byte_out   = byte_out_q;
    assign io.byte_valid = byte_valid_q;
    assign io.busy       = (state_q == ACCUM) || (state_q == PACK) || (state_q == OUT);
    assign io.done       = (state_q == DONE);
`ifdef PIXEL_COUNT_EN
    assign io.edge_count = edge_cnt_q;
`endif
endmodule
